// File: rtl/ropuf_meas_ctrl.sv
// Measurement sequencer for one RO-PUF chain: two windowed edge counts under
// challenges A and B, compared into a single response bit.
module ropuf_meas_ctrl #(
  parameter int SETTLE = 4,
  parameter int WIN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       chal_a,
  input  logic [7:0]       chal_b,
  input  logic [WIN_W-1:0] window,
  input  logic             ro_out,
  output logic             puf_en,
  output logic [7:0]       puf_c,
  output logic             puf_s,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic             sat,
  output logic             err,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // state   | meaning
  // IDLE    | waiting for start, chain off, puf_c = 0
  // SETUP_A | chain disabled, challenge A applied, puf_s high, SETTLE cycles
  // MEAS_A  | chain enabled, edges counted into cnt_a, window cycles
  // DRAIN_A | chain disabled, synchroniser tail still counted into cnt_a, 2 cycles
  // SETUP_B | as SETUP_A with challenge B
  // MEAS_B  | as MEAS_A, counting into cnt_b
  // DRAIN_B | as DRAIN_A, counting into cnt_b
  // CMP     | response/tie computed from the two counts
  // DONE    | done pulse registered, back to IDLE
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SETUP_A = 4'd1;
  localparam logic [3:0] S_MEAS_A  = 4'd2;
  localparam logic [3:0] S_DRAIN_A = 4'd3;
  localparam logic [3:0] S_SETUP_B = 4'd4;
  localparam logic [3:0] S_MEAS_B  = 4'd5;
  localparam logic [3:0] S_DRAIN_B = 4'd6;
  localparam logic [3:0] S_CMP     = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE - 1);
  localparam logic [WIN_W-1:0] DRAIN_LD  = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [3:0]       state;
  logic [WIN_W-1:0] tmr;
  logic [WIN_W-1:0] win_q;
  logic [7:0]       chal_a_q;
  logic [7:0]       chal_b_q;
  logic [1:0]       sync_q;
  logic             hist_q;
  logic             rise;
  logic             tmr_tc;
  logic             count_a;
  logic             count_b;
  logic             phase_a;
  logic             phase_b;

  assign rise    = sync_q[1] & ~hist_q;
  assign tmr_tc  = (tmr == '0);
  assign count_a = (state == S_MEAS_A) || (state == S_DRAIN_A);
  assign count_b = (state == S_MEAS_B) || (state == S_DRAIN_B);
  assign phase_a = (state == S_SETUP_A) || count_a;
  assign phase_b = (state == S_SETUP_B) || count_b || (state == S_CMP) || (state == S_DONE);

  assign busy   = (state != S_IDLE);
  assign puf_en = (state == S_MEAS_A) || (state == S_MEAS_B);
  assign puf_s  = (state == S_SETUP_A) || (state == S_SETUP_B);
  assign puf_c  = phase_a ? chal_a_q : (phase_b ? chal_b_q : 8'h00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      win_q    <= '0;
      chal_a_q <= '0;
      chal_b_q <= '0;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      done     <= 1'b0;
      response <= 1'b0;
      tie      <= 1'b0;
      sat      <= 1'b0;
      err      <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
    end else begin
      sync_q <= {sync_q[0], ro_out};
      hist_q <= sync_q[1];
      done   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            chal_a_q <= chal_a;
            chal_b_q <= chal_b;
            win_q    <= window;
            cnt_a    <= '0;
            cnt_b    <= '0;
            sat      <= 1'b0;
            response <= 1'b0;
            tie      <= 1'b0;
            if (window == '0) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              tmr   <= SETTLE_LD;
              state <= S_SETUP_A;
            end
          end
        end
        S_SETUP_A, S_SETUP_B: begin
          if (tmr_tc) begin
            tmr   <= win_q - WIN_W'(1);
            state <= (state == S_SETUP_A) ? S_MEAS_A : S_MEAS_B;
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        S_MEAS_A, S_MEAS_B: begin
          if (tmr_tc) begin
            tmr   <= DRAIN_LD;
            state <= (state == S_MEAS_A) ? S_DRAIN_A : S_DRAIN_B;
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        S_DRAIN_A: begin
          if (tmr_tc) begin
            tmr   <= SETTLE_LD;
            state <= S_SETUP_B;
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        S_DRAIN_B: begin
          if (tmr_tc) state <= S_CMP;
          else        tmr   <= tmr - WIN_W'(1);
        end
        S_CMP: begin
          response <= (cnt_a > cnt_b);
          tie      <= (cnt_a == cnt_b);
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // sat flags an edge that arrived while the counter was already pinned
      if (count_a && rise) begin
        if (cnt_a == CNT_MAX) sat   <= 1'b1;
        else                  cnt_a <= cnt_a + CNT_W'(1);
      end
      if (count_b && rise) begin
        if (cnt_b == CNT_MAX) sat   <= 1'b1;
        else                  cnt_b <= cnt_b + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ropuf_meas_ctrl.sv
// Randomised scoreboard bench for ropuf_meas_ctrl: a square-wave RO model feeds
// the DUT and expected counts come from closed-form edge arithmetic.
module tb_ropuf_meas_ctrl;
  localparam int SETTLE = 4;
  localparam int WIN_W  = 16;
  localparam int CNT_W  = 5;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       chal_a = '0;
  logic [7:0]       chal_b = '0;
  logic [WIN_W-1:0] window = '0;
  logic             ro_out = 1'b0;
  logic             puf_en, puf_s, busy, done, response, tie, sat, err;
  logic [7:0]       puf_c;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  ropuf_meas_ctrl #(.SETTLE(SETTLE), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chal_a(chal_a), .chal_b(chal_b),
    .window(window), .ro_out(ro_out), .puf_en(puf_en), .puf_c(puf_c), .puf_s(puf_s),
    .busy(busy), .done(done), .response(response), .tie(tie), .sat(sat), .err(err),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    bit err, resp, tie, sat;
    int ca, cb;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int cur_pa = 2, cur_pb = 2;
  logic [7:0] cur_ca = '0, cur_cb = '0;
  bit ph = 1'b0;
  int k = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, req);
    end
  endtask

  // rising edges of a square wave (low for p/2, high for the rest) seen in w samples
  function automatic int edges(input int w, input int p);
    if (w <= p / 2) return 0;
    return (w - 1 - p / 2) / p + 1;
  endfunction

  function automatic int latency(input int w);
    if (w == 0) return 1;
    return 2 * (SETTLE + w + 2) + 2;
  endfunction

  function automatic exp_t model(input int w, input int pa, input int pb);
    exp_t e;
    int ea, eb;
    ea = (w == 0) ? 0 : edges(w, pa);
    eb = (w == 0) ? 0 : edges(w, pb);
    e.t    = 0;
    e.err  = (w == 0);
    e.sat  = (ea > MAXC) || (eb > MAXC);
    e.ca   = (ea > MAXC) ? MAXC : ea;
    e.cb   = (eb > MAXC) ? MAXC : eb;
    e.resp = e.ca > e.cb;
    e.tie  = (w != 0) && (e.ca == e.cb);
    return e;
  endfunction

  // RO chain stand-in: square wave restarted low at each enable, period per phase
  always @(posedge clk) begin
    #1;
    if (rst_n && puf_en) begin
      int p;
      p = ph ? cur_pb : cur_pa;
      ro_out = ((k % p) >= p / 2);
      k++;
      check("puf_c", puf_c, ph ? cur_cb : cur_ca);
      check("puf_s_meas", puf_s, 0);
    end else begin
      ro_out = 1'b0;
      if (k != 0) ph = ~ph;
      k = 0;
      if (!busy) ph = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, want done=0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.t);
        check("err", err, e.err);
        check("response", response, e.resp);
        check("tie", tie, e.tie);
        check("sat", sat, e.sat);
        check("cnt_a", cnt_a, e.ca);
        check("cnt_b", cnt_b, e.cb);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout at cycle %0d: got busy=1, want busy=0", cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout at cycle %0d: got %0d pending, want 0", cyc, sb.size());
      sb.delete();
    end
  endtask

  task automatic setup_req(input logic [7:0] ca, input logic [7:0] cb, input int w,
                           input int pa, input int pb);
    chal_a = ca;
    chal_b = cb;
    window = WIN_W'(w);
    cur_ca = ca;
    cur_cb = cb;
    cur_pa = pa;
    cur_pb = pb;
  endtask

  task automatic issue(input logic [7:0] ca, input logic [7:0] cb, input int w,
                       input int pa, input int pb);
    exp_t e;
    wait_idle();
    setup_req(ca, cb, w, pa, pb);
    e = model(w, pa, pb);
    e.t = cyc + 1 + latency(w);
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_puf_en"}, puf_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_puf_c"}, puf_c, 0);
    check({tag, "_puf_s"}, puf_s, 0);
    check({tag, "_flags"}, {response, tie, sat, err}, 0);
    check({tag, "_cnt_a"}, cnt_a, 0);
    check({tag, "_cnt_b"}, cnt_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cycle %0d: got no finish, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    exp_t e1, e2;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-MEAS_A after some edges have been counted
    issue(8'h11, 8'h22, 80, 2, 4);
    n = 0;
    while (!puf_en && n < 100) begin @(negedge clk); n++; end
    check("meas_a_reached", puf_en, 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue(8'h3C, 8'hA5, 100, 6, 10);
    drain();
    issue(8'h3C, 8'hA5, 100, 10, 6);
    drain();
    issue(8'h5A, 8'h5B, 64, 8, 8);
    drain();

    issue(8'h77, 8'h88, 0, 4, 4);
    repeat (4) begin
      check("err_puf_en", puf_en, 0);
      @(negedge clk);
    end
    drain();

    // saturation, with a stray start during MEAS_B
    issue(8'hC3, 8'h3C, 64, 2, 2);
    n = 0;
    while (!(puf_en && ph) && n < 400) begin @(negedge clk); n++; end
    check("meas_b_reached", puf_en && ph, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // start held high: second request accepted right after the first completes
    wait_idle();
    setup_req(8'h0F, 8'hF0, 30, 4, 6);
    e1 = model(30, 4, 6);
    e1.t = cyc + 1 + latency(30);
    e2 = e1;
    e2.t = e1.t + 1 + latency(30);
    sb.push_back(e1);
    sb.push_back(e2);
    start = 1'b1;
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 100));
      issue(8'($urandom), 8'($urandom), w, int'($urandom_range(2, 12)),
            int'($urandom_range(2, 12)));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
